mem_responder: RTL

Wait-state data-memory responder for the pipeline CPU's data bus. It sits between the core's data-memory port (read enable, write enable, translated address, shared bidirectional data) and an on-chip word array. It accepts one request at a time, stalls the core for a programmable number of wait states, and then completes the read or write. Read data is driven onto the shared data bus only during the response cycle.

---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/mem_resp_array.sv | 26 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
// Used by mem_responder and mem_resp_array.
package mem_resp_pkg;

  localparam int unsigned DefAddrW = 20;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word array: synchronous write, combinational read from the same index.
// Contents are deliberately not reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [idx_width(DEPTH)-1:0]  idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Wait-state data-memory responder: one request at a time, programmable stall, read data
// driven on the shared bus only in the response cycle. Alignment/range checking: MEM_RESP_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy,
  output logic              rvalid,
  output logic              err
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  localparam int unsigned CntW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IdxW-1:0]   idx_in;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_word;
  logic              mem_wr;
  logic              req_legal;
  logic              req_both;
  logic              in_resp;

  assign req_legal = re ^ we;
  assign req_both  = re & we;
  assign in_resp   = (state_q == StResp);
  // Word index wraps modulo DEPTH even when DEPTH is not a power of two.
  assign idx_in    = IdxW'(64'(adr[ADDR_W-1:2]) % 64'(DEPTH));

`ifdef MEM_RESP_CHECK_EN
  logic bad_q, bad_in;

  assign bad_in = (adr[1:0] != 2'b00) || (64'(adr[ADDR_W-1:2]) >= 64'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_q <= 1'b0;
    end else if (state_q == StIdle && req_legal) begin
      bad_q <= bad_in;
    end
  end

  assign rd_word = bad_q ? '0 : arr_rdata;
  assign mem_wr  = in_resp && op_we_q && !bad_q;
  assign err     = reset && ((state_q == StIdle && req_both) || (in_resp && bad_q));
`else
  logic unused_lanes;

  assign unused_lanes = ^adr[1:0];
  assign rd_word      = arr_rdata;
  assign mem_wr       = in_resp && op_we_q;
  assign err          = reset && (state_q == StIdle) && req_both;
`endif

  assign busy   = reset && ((state_q == StIdle && req_legal) || state_q == StWait);
  assign rvalid = in_resp && !op_we_q;
  assign data   = rvalid ? rd_word : {DATA_W{1'bz}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_legal) begin
          op_we_d = we;
          idx_d   = idx_in;
          cnt_d   = CntW'(WAIT_STATES);
          if (we) begin
            wdata_d = data;
          end
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_wr),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule
